db_mv_scan_ctrl: RTL and testbench
==================================

// Module: db_mv_scan_ctrl
// PURPOSE
//  Sequencer for the deblocking MV store of one 64x64 LCU (db_mv_ram instantiated inside).
//  Accepts MV writes while idle, then on start streams current/neighbour MV pairs to BS calc:
//  64 vertical-edge pairs, then 64 horizontal-edge pairs; one-cycle RAM latency, backpressure.
//  Map: addr 0..63 = 8x8 blocks (r*8+c), 64..71 = left column (64+r), 72..79 = top row (72+c).
// PARAMETERS
//  MV_W     2*`FMV_WIDTH  width of one stored MV entry
//  ADDR_W   7             MV RAM address width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       synchronous reset, active low
//  mv_wr_val_i  in   1       MV write request
//  mv_wr_rdy_o  out  1       write accepted (IDLE only)
//  mv_wr_addr_i in   ADDR_W  write address (0..79)
//  mv_wr_dat_i  in   MV_W    write data
//  start_i      in   1       begin scan (sampled in IDLE only)
//  busy_o       out  1       state != IDLE
//  out_val_o    out  1       MV pair valid
//  out_rdy_i    in   1       consumer accepts pair
//  out_dir_o    out  1       0 = vertical edge, 1 = horizontal edge
//  out_idx_o    out  6       current block index r*8+c
//  out_ext_o    out  1       neighbour lies outside LCU (left column / top row entry)
//  out_cur_o    out  MV_W    MV of current block (RAM port A)
//  out_nbr_o    out  MV_W    MV of neighbour block (RAM port B)
//  done_o       out  1       one-cycle pulse, last pair accepted
// BEHAVIOUR
//  Clock clk; reset synchronous active-low (rst_n): state IDLE, counters 0, out_val_o/done_o/
//   busy_o 0, out_dir/idx/ext 0; RAM contents not cleared; reset mid-scan aborts, no done_o.
//  FSM: IDLE -> SCAN_V (start_i) -> SCAN_H (after 64th V read issued) -> DRAIN -> IDLE.
//  IDLE: mv_wr_rdy_o=1; write on val&rdy via port A (cena=0,wena=0); port B idle.
//   start_i with write same cycle: write commits, FSM enters SCAN_V next cycle.
//  SCAN: issue = !out_val_o | out_rdy_i. On issue: port A read cur, port B read nbr
//   (cen=0, wen=1); ren tied 0. Next cycle out_val_o=1, tags registered with the read.
//  No issue: cen=1, RAM output regs hold -> out_cur/out_nbr stable while stalled.
//  V pair: cur=r*8+c; nbr = c==0 ? 64+r : cur-1; ext=(c==0).
//  H pair: cur=r*8+c; nbr = r==0 ? 72+c : cur-8; ext=(r==0).
//  Counter 6-bit idx, c=idx[2:0], r=idx[5:3]; wraps 63->0 on V->H switch, no bubble.
//  DRAIN: no reads; when final pair accepted: out_val_o->0, done_o=1 one cycle, IDLE.
//  Throughput: 1 pair/cycle with out_rdy_i=1; 128 pairs, done_o at cycle 130 after start.
//  mv_wr_val_i outside IDLE ignored (rdy=0); start_i outside IDLE ignored.
//  Write addresses 80..127 accepted and stored, never scanned.
// STRUCTURE
//  Shared enc_defines: FMV_WIDTH; LCU map constants (LEFT_BASE=64, TOP_BASE=72, NBLK=64).
//  Local localparams: FSM state encoding (2 bits).
//  Sub-module: db_mv_ram (one instance, clka=clkb=clk); all other logic in this module.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> out_val_o=0, busy_o=0, done_o=0, mv_wr_rdy_o=1.
//  2 Load addr k with data k (0..79), start, out_rdy_i=1 -> V idx0: cur=0,nbr=64,ext=1;
//    V idx9: cur=9,nbr=8; H idx3: cur=3,nbr=75,ext=1; H idx12: cur=12,nbr=4; done_o cycle 130.
//  3 Random out_rdy_i (50%) -> same 128 pairs in order, data stable during stall, no loss/dup.
//  4 Write while busy -> mv_wr_rdy_o=0, RAM unchanged (rescan compares identical).
//  5 rst_n=0 at pair 70 -> IDLE next cycle, no done_o; new start gives full 128-pair sequence.
//  6 start_i with write to addr 5 same cycle -> write stored; V idx5 cur=new data.

Source files
------------

// File: rtl/db_mv_scan_ctrl_pkg.sv
// Shared definitions for the deblocking MV scan controller.
// Latency: n/a (types, constants and address helpers only).
// Backpressure: n/a.
package db_mv_scan_ctrl_pkg;

  // Width of one motion-vector component; a stored entry holds an (x, y) pair.
  localparam int FMV_WIDTH = 10;
  localparam int MV_W      = 2 * FMV_WIDTH;
  localparam int ADDR_W    = 7;

  // LCU MV store map: 0..63 = 8x8 blocks (r*8+c), 64..71 left column, 72..79 top row.
  localparam int NBLK = 64;
  localparam logic [ADDR_W-1:0] LEFT_BASE = 7'd64;
  localparam logic [ADDR_W-1:0] TOP_BASE  = 7'd72;

  // Neighbour address for block idx. dir=0: left neighbour (vertical edge),
  // dir=1: upper neighbour (horizontal edge). Blocks on the LCU border pick
  // their neighbour from the stored left column / top row instead.
  function automatic logic [ADDR_W-1:0] nbr_addr(input logic dir, input logic [5:0] idx);
    logic [ADDR_W-1:0] cur;
    cur = ADDR_W'(idx);
    if (dir) begin
      nbr_addr = (idx[5:3] == 3'd0) ? TOP_BASE + ADDR_W'(idx[2:0]) : cur - ADDR_W'(8);
    end else begin
      nbr_addr = (idx[2:0] == 3'd0) ? LEFT_BASE + ADDR_W'(idx[5:3]) : cur - ADDR_W'(1);
    end
  endfunction

  // Neighbour lies outside the LCU (left column for V edges, top row for H edges).
  function automatic logic nbr_ext(input logic dir, input logic [5:0] idx);
    nbr_ext = dir ? (idx[5:3] == 3'd0) : (idx[2:0] == 3'd0);
  endfunction

endpackage

// File: rtl/db_mv_scan_ctrl_ram.sv
// MV store RAM: port A read/write, port B read-only, active-low enables.
// Latency: one cycle from enabled read to registered dout.
// Backpressure: none; when a port is not enabled its dout register holds.
//
// Ports: clka/cena/wena/addra/dina/douta (A, wena=0 writes when cena=0),
//        clkb/cenb/addrb/doutb (B, read when cenb=0).
module db_mv_ram #(
  parameter int DW = 20,
  parameter int AW = 7
) (
  input  logic          clka,
  input  logic          cena,
  input  logic          wena,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  input  logic          clkb,
  input  logic          cenb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb
);

  logic [DW-1:0] mem [2**AW];

  // Contents are never reset; a write does not update the read register.
  always_ff @(posedge clka) begin
    if (!cena) begin
      if (!wena) begin
        mem[addra] <= dina;
      end else begin
        douta <= mem[addra];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (!cenb) begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/db_mv_scan_ctrl.sv
// Deblocking MV store sequencer for one 64x64 LCU: loads MVs while idle, then
// streams 64 vertical-edge then 64 horizontal-edge (cur, nbr) MV pairs.
// Latency: one cycle read-to-valid; 1 pair/cycle, done_o 130 cycles after start.
// Backpressure: out_val_o/out_rdy_i; no new read issued while a pair is stalled.
//
// Ports: clk, rst_n (sync, active low); mv_wr_val_i/mv_wr_rdy_o/mv_wr_addr_i/mv_wr_dat_i
//        write port (IDLE only); start_i, busy_o, done_o; out_val_o/out_rdy_i with
//        out_dir_o, out_idx_o, out_ext_o, out_cur_o, out_nbr_o.
module db_mv_scan_ctrl
  import db_mv_scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mv_wr_val_i,
  output logic              mv_wr_rdy_o,
  input  logic [ADDR_W-1:0] mv_wr_addr_i,
  input  logic [MV_W-1:0]   mv_wr_dat_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              out_val_o,
  input  logic              out_rdy_i,
  output logic              out_dir_o,
  output logic [5:0]        out_idx_o,
  output logic              out_ext_o,
  output logic [MV_W-1:0]   out_cur_o,
  output logic [MV_W-1:0]   out_nbr_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN_V = 2'd1,
    ST_SCAN_H = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        out_val_q, out_val_d;
  logic        out_dir_q, out_dir_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_ext_q, out_ext_d;
  logic        done_q, done_d;

  logic              cena, wena, cenb;
  logic [ADDR_W-1:0] addra, addrb;
  logic              scan_dir;
  logic              issue;

  assign scan_dir = (state_q == ST_SCAN_H);
  // A new read may be issued when the output slot is empty or being emptied.
  assign issue    = ((state_q == ST_SCAN_V) || (state_q == ST_SCAN_H)) &&
                    (!out_val_q || out_rdy_i);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_val_d = out_val_q;
    out_dir_d = out_dir_q;
    out_idx_d = out_idx_q;
    out_ext_d = out_ext_q;
    done_d    = 1'b0;
    cena      = 1'b1;
    wena      = 1'b1;
    cenb      = 1'b1;
    addra     = mv_wr_addr_i;
    addrb     = '0;

    case (state_q)
      ST_IDLE: begin
        if (mv_wr_val_i) begin
          cena = 1'b0;
          wena = 1'b0;
        end
        if (start_i) begin
          state_d = ST_SCAN_V;
          idx_d   = '0;
        end
      end

      ST_SCAN_V, ST_SCAN_H: begin
        if (issue) begin
          cena      = 1'b0;
          cenb      = 1'b0;
          addra     = ADDR_W'(idx_q);
          addrb     = nbr_addr(scan_dir, idx_q);
          out_val_d = 1'b1;
          out_dir_d = scan_dir;
          out_idx_d = idx_q;
          out_ext_d = nbr_ext(scan_dir, idx_q);
          // The counter wraps 63->0 at the V->H switch with no bubble.
          idx_d     = idx_q + 6'd1;
          if (idx_q == 6'(NBLK - 1)) begin
            state_d = (state_q == ST_SCAN_V) ? ST_SCAN_H : ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // The last pair is already in the output slot; wait for its acceptance.
        if (out_rdy_i) begin
          out_val_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      out_val_q <= 1'b0;
      out_dir_q <= 1'b0;
      out_idx_q <= '0;
      out_ext_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_val_q <= out_val_d;
      out_dir_q <= out_dir_d;
      out_idx_q <= out_idx_d;
      out_ext_q <= out_ext_d;
      done_q    <= done_d;
    end
  end

  db_mv_ram #(
    .DW (MV_W),
    .AW (ADDR_W)
  ) u_mv_ram (
    .clka  (clk),
    .cena  (cena),
    .wena  (wena),
    .addra (addra),
    .dina  (mv_wr_dat_i),
    .douta (out_cur_o),
    .clkb  (clk),
    .cenb  (cenb),
    .addrb (addrb),
    .doutb (out_nbr_o)
  );

  assign mv_wr_rdy_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_val_o   = out_val_q;
  assign out_dir_o   = out_dir_q;
  assign out_idx_o   = out_idx_q;
  assign out_ext_o   = out_ext_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_db_mv_scan_ctrl.sv
// Self-checking bench for db_mv_scan_ctrl: scoreboard of expected MV pairs,
// stall-stability monitor, directed reset / load / scan / abort sequences.
module tb_db_mv_scan_ctrl;
  import db_mv_scan_ctrl_pkg::*;

  typedef struct packed {
    logic            dir;
    logic [5:0]      idx;
    logic            ext;
    logic [MV_W-1:0] cur;
    logic [MV_W-1:0] nbr;
  } pair_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mv_wr_val_i;
  logic              mv_wr_rdy_o;
  logic [ADDR_W-1:0] mv_wr_addr_i;
  logic [MV_W-1:0]   mv_wr_dat_i;
  logic              start_i;
  logic              busy_o;
  logic              out_val_o;
  logic              out_rdy_i;
  logic              out_dir_o;
  logic [5:0]        out_idx_o;
  logic              out_ext_o;
  logic [MV_W-1:0]   out_cur_o;
  logic [MV_W-1:0]   out_nbr_o;
  logic              done_o;

  db_mv_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mv_wr_val_i  (mv_wr_val_i),
    .mv_wr_rdy_o  (mv_wr_rdy_o),
    .mv_wr_addr_i (mv_wr_addr_i),
    .mv_wr_dat_i  (mv_wr_dat_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .out_val_o    (out_val_o),
    .out_rdy_i    (out_rdy_i),
    .out_dir_o    (out_dir_o),
    .out_idx_o    (out_idx_o),
    .out_ext_o    (out_ext_o),
    .out_cur_o    (out_cur_o),
    .out_nbr_o    (out_nbr_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_acc = 0;
  pair_t sb [$];
  logic [MV_W-1:0] model [128];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected 128-pair sequence from the current model contents.
  task automatic push_scan();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        int r, c, n;
        pair_t p;
        r = i / 8;
        c = i % 8;
        if (d == 0) n = (c == 0) ? 64 + r : i - 1;
        else        n = (r == 0) ? 72 + c : i - 8;
        p.dir = (d == 1);
        p.idx = 6'(i);
        p.ext = (d == 0) ? (c == 0) : (r == 0);
        p.cur = model[i];
        p.nbr = model[n];
        sb.push_back(p);
      end
    end
  endtask

  // Output monitor: pops on each accepted pair and checks stalled data holds.
  pair_t obs_p, held_p, exp_p;
  bit    stalled = 0;
  always @(negedge clk) begin
    obs_p = {out_dir_o, out_idx_o, out_ext_o, out_cur_o, out_nbr_o};
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_val", 64'(out_val_o), 64'd1);
        check("stall_dat", 64'(obs_p), 64'(held_p));
      end
      if (out_val_o && out_rdy_i) begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL extra_pair: observed idx %0d dir %0d, expected none", out_idx_o, out_dir_o);
        end
        if (sb.size() != 0) begin
          exp_p = sb.pop_front();
          check("pair", 64'(obs_p), 64'(exp_p));
        end
        n_acc++;
      end
      stalled = out_val_o && !out_rdy_i;
      held_p  = obs_p;
    end
  end

  // Start a scan, run until done_o (bounded), then check completion.
  task automatic run_scan(input bit rand_rdy, input bit wr_busy);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    start_i = 1'b1;
    push_scan();
    while (cyc < 2000 && !got) begin
      @(posedge clk);
      cyc++;
      #1;
      start_i = 1'b0;
      if (cyc == 1) mv_wr_val_i = wr_busy;
      if (wr_busy && cyc == 1) begin
        mv_wr_addr_i = 7'd10;
        mv_wr_dat_i  = 20'h55555;
      end
      if (wr_busy && cyc == 5) check("wr_rdy_busy", 64'(mv_wr_rdy_o), 64'd0);
      if (cyc == 20) mv_wr_val_i = 1'b0;
      if (done_o) got = 1;
      else if (rand_rdy) out_rdy_i = 1'($urandom_range(0, 1));
    end
    check("done_seen", 64'(got), 64'd1);
    if (!rand_rdy) check("done_cycle", 64'(cyc), 64'd130);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("val_after_done", 64'(out_val_o), 64'd0);
    out_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done_o), 64'd0);
    check("idle_after", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int base, lim;
    rst_n        = 1'b0;
    mv_wr_val_i  = 1'b0;
    mv_wr_addr_i = '0;
    mv_wr_dat_i  = '0;
    start_i      = 1'b0;
    out_rdy_i    = 1'b1;
    for (int k = 0; k < 128; k++) model[k] = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_val", 64'(out_val_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_wr_rdy", 64'(mv_wr_rdy_o), 64'd1);
    rst_n = 1'b1;

    // Load addr k with data k for the whole map
    for (int k = 0; k < 80; k++) begin
      mv_wr_val_i  = 1'b1;
      mv_wr_addr_i = 7'(k);
      mv_wr_dat_i  = 20'(k);
      model[k]     = 20'(k);
      @(posedge clk);
      #1;
    end
    mv_wr_val_i = 1'b0;

    // Full-rate scan
    run_scan(1'b0, 1'b0);

    // Random backpressure
    run_scan(1'b1, 1'b0);

    // Writes attempted while busy must be dropped
    run_scan(1'b0, 1'b1);

    // Reset in the middle of a scan, then a clean rescan
    base = n_acc;
    lim  = 0;
    start_i = 1'b1;
    push_scan();
    while ((n_acc - base) < 70 && lim < 500) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      lim++;
    end
    check("abort_reached", 64'(n_acc - base), 64'd70);
    out_rdy_i = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_val", 64'(out_val_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", 64'(done_o), 64'd0);
      @(posedge clk);
      #1;
    end
    out_rdy_i = 1'b1;
    run_scan(1'b0, 1'b0);

    // Write coinciding with start commits before the scan
    mv_wr_val_i  = 1'b1;
    mv_wr_addr_i = 7'd5;
    mv_wr_dat_i  = 20'hABCDE;
    model[5]     = 20'hABCDE;
    run_scan(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
